// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Which requester owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_PIPE = 2'd1,
        WB_SRC_LU   = 2'd2
    } wb_src_e;

    // x0 is hardwired to zero: never written, never pending.
    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
        return (addr == '0);
    endfunction

endpackage

// File: rtl/wb_port_arbiter_regf_scoreboard.sv
// Per-register pending bits for long-latency destinations.
// Set on issue, clear on commit; a set and clear of the same
// index in one cycle leaves the bit set. x0 is never pending.
module wb_port_arbiter_regf_scoreboard
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  i_set,
    input  logic [REG_ADDR_W-1:0] i_set_addr,
    input  logic                  i_clr,
    input  logic [REG_ADDR_W-1:0] i_clr_addr,
    input  logic [REG_ADDR_W-1:0] i_rd_addr0,
    input  logic [REG_ADDR_W-1:0] i_rd_addr1,
    input  logic [REG_ADDR_W-1:0] i_rd_addr2,
    output logic                  o_rd_pend0,
    output logic                  o_rd_pend1,
    output logic                  o_rd_pend2,
    output logic [NUM_REGS-1:0]   o_pending
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_pending_nxt;

    // Next pending vector: apply clear first so a same-index set wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_clr) begin
            w_pending_nxt[i_clr_addr] = 1'b0;
        end
        if (i_set && !is_x0(i_set_addr)) begin
            w_pending_nxt[i_set_addr] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    // Pending state register; reset drops every outstanding destination.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Three combinational read ports for decode, x0 forced to not-pending.
    always_comb begin
        o_rd_pend0 = !is_x0(i_rd_addr0) && r_pending[i_rd_addr0];
        o_rd_pend1 = !is_x0(i_rd_addr1) && r_pending[i_rd_addr1];
        o_rd_pend2 = !is_x0(i_rd_addr2) && r_pending[i_rd_addr2];
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has fixed
// priority, long-latency results wait in a one-entry buffer and drain
// into free slots; a starvation counter requests a WB bubble.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int NUM_REGS = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  pipe_write_i,
    input  logic [REG_ADDR_W-1:0] pipe_waddr_i,
    input  logic [XLEN-1:0]       pipe_wdata_i,
    input  logic                  lu_valid_i,
    output logic                  lu_ready_o,
    input  logic [REG_ADDR_W-1:0] lu_waddr_i,
    input  logic [XLEN-1:0]       lu_wdata_i,
    input  logic                  lu_issue_i,
    input  logic [REG_ADDR_W-1:0] lu_issue_rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic                  hazard_o,
    output logic                  pipe_stall_o,
    output logic                  regf_write_o,
    output logic [REG_ADDR_W-1:0] regf_waddr_o,
    output logic [XLEN-1:0]       regf_wdata_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    // Holding buffer and starvation state.
    logic                  r_buf_valid;
    logic [REG_ADDR_W-1:0] r_buf_waddr;
    logic [XLEN-1:0]       r_buf_wdata;
    logic [CNT_W-1:0]      r_starve_cnt;

    logic                  w_pipe_slot;
    logic                  w_accept;
    logic                  w_commit;
    wb_src_e               w_src;
    logic                  w_pend_rs1;
    logic                  w_pend_rs2;
    logic                  w_pend_rd;
    logic [NUM_REGS-1:0]   w_pending;

    // A write to x0 is a free slot: it never reaches the register file.
    assign w_pipe_slot = pipe_write_i && !is_x0(pipe_waddr_i);

    // Ready depends only on registered state, so accept and commit never overlap.
    assign lu_ready_o = !r_buf_valid;
    assign w_accept   = lu_valid_i && lu_ready_o;
    assign w_commit   = r_buf_valid && !w_pipe_slot;

    assign pipe_stall_o = (r_starve_cnt == CNT_MAX);

    // Port-mux select: pipeline first, then the buffered result.
    always_comb begin
        w_src = WB_SRC_NONE;
        if (w_pipe_slot) begin
            w_src = WB_SRC_PIPE;
        end else if (r_buf_valid) begin
            w_src = WB_SRC_LU;
        end
    end

    // Drive the register-file write port from the selected source.
    always_comb begin
        regf_write_o = 1'b0;
        regf_waddr_o = '0;
        regf_wdata_o = '0;
        case (w_src)
            WB_SRC_PIPE: begin
                regf_write_o = 1'b1;
                regf_waddr_o = pipe_waddr_i;
                regf_wdata_o = pipe_wdata_i;
            end
            WB_SRC_LU: begin
                regf_write_o = 1'b1;
                regf_waddr_o = r_buf_waddr;
                regf_wdata_o = r_buf_wdata;
            end
            default: begin
                regf_write_o = 1'b0;
            end
        endcase
    end

    // Buffer occupancy: fill on accept, drain on commit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_buf_valid <= 1'b0;
        end else if (w_accept) begin
            r_buf_valid <= 1'b1;
        end else if (w_commit) begin
            r_buf_valid <= 1'b0;
        end
    end

    // Buffer payload, captured only on accept; no reset needed for data.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_buf_waddr <= lu_waddr_i;
            r_buf_wdata <= lu_wdata_i;
        end
    end

    // Starvation counter: counts cycles the full buffer loses the port, saturating.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_starve_cnt <= '0;
        end else if (!r_buf_valid || w_commit) begin
            r_starve_cnt <= '0;
        end else if (w_pipe_slot && (r_starve_cnt != CNT_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    wb_port_arbiter_regf_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .i_set      (lu_issue_i),
        .i_set_addr (lu_issue_rd_i),
        .i_clr      (w_commit),
        .i_clr_addr (r_buf_waddr),
        .i_rd_addr0 (rs1_addr_i),
        .i_rd_addr1 (rs2_addr_i),
        .i_rd_addr2 (rd_addr_i),
        .o_rd_pend0 (w_pend_rs1),
        .o_rd_pend1 (w_pend_rs2),
        .o_rd_pend2 (w_pend_rd),
        .o_pending  (w_pending)
    );

    // No forwarding: decode stalls while any operand is still outstanding.
    assign hazard_o = w_pend_rs1 | w_pend_rs2 | w_pend_rd;

    // The core must leave the WB slot empty whenever a bubble is requested.
    a_stall_no_pipe_write: assert property (
        @(posedge clk_i) disable iff (!rstn_i)
        pipe_stall_o |-> !pipe_write_i
    );

    // Re-issuing to a pending rd is only tolerated when that rd commits the same cycle.
    a_issue_not_pending: assert property (
        @(posedge clk_i) disable iff (!rstn_i)
        (lu_issue_i && !is_x0(lu_issue_rd_i) && w_pending[lu_issue_rd_i])
            |-> (w_commit && (r_buf_waddr == lu_issue_rd_i))
    );

    // The pipeline must never overwrite a register a long-latency op still owns.
    a_pipe_write_not_pending: assert property (
        @(posedge clk_i) disable iff (!rstn_i)
        w_pipe_slot |-> !w_pending[pipe_waddr_i]
    );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        pipe_write_i;
    logic [4:0]  pipe_waddr_i;
    logic [31:0] pipe_wdata_i;
    logic        lu_valid_i;
    logic        lu_ready_o;
    logic [4:0]  lu_waddr_i;
    logic [31:0] lu_wdata_i;
    logic        lu_issue_i;
    logic [4:0]  lu_issue_rd_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [4:0]  rd_addr_i;
    logic        hazard_o;
    logic        pipe_stall_o;
    logic        regf_write_o;
    logic [4:0]  regf_waddr_o;
    logic [31:0] regf_wdata_o;

    int n_vec  = 0;
    int n_miss = 0;

    wb_port_arbiter #(
        .MAX_WAIT (MAX_WAIT),
        .NUM_REGS (32)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .pipe_write_i  (pipe_write_i),
        .pipe_waddr_i  (pipe_waddr_i),
        .pipe_wdata_i  (pipe_wdata_i),
        .lu_valid_i    (lu_valid_i),
        .lu_ready_o    (lu_ready_o),
        .lu_waddr_i    (lu_waddr_i),
        .lu_wdata_i    (lu_wdata_i),
        .lu_issue_i    (lu_issue_i),
        .lu_issue_rd_i (lu_issue_rd_i),
        .rs1_addr_i    (rs1_addr_i),
        .rs2_addr_i    (rs2_addr_i),
        .rd_addr_i     (rd_addr_i),
        .hazard_o      (hazard_o),
        .pipe_stall_o  (pipe_stall_o),
        .regf_write_o  (regf_write_o),
        .regf_waddr_o  (regf_waddr_o),
        .regf_wdata_o  (regf_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        pipe_write_i  = 1'b0;
        pipe_waddr_i  = '0;
        pipe_wdata_i  = '0;
        lu_valid_i    = 1'b0;
        lu_waddr_i    = '0;
        lu_wdata_i    = '0;
        lu_issue_i    = 1'b0;
        lu_issue_rd_i = '0;
        rs1_addr_i    = '0;
        rs2_addr_i    = '0;
        rd_addr_i     = '0;
    endtask

    initial begin
        idle_inputs();
        rstn_i = 1'b0;
        settle();

        // Reset state, checked while reset is asserted.
        chk("rst_lu_ready", 32'(lu_ready_o), 32'd1);
        chk("rst_stall",    32'(pipe_stall_o), 32'd0);
        chk("rst_hazard",   32'(hazard_o), 32'd0);
        chk("rst_write",    32'(regf_write_o), 32'd0);
        step();
        step();
        rstn_i = 1'b1;
        step();

        // Idle after reset.
        settle();
        chk("idle_write",    32'(regf_write_o), 32'd0);
        chk("idle_lu_ready", 32'(lu_ready_o), 32'd1);
        chk("idle_hazard",   32'(hazard_o), 32'd0);
        chk("idle_stall",    32'(pipe_stall_o), 32'd0);

        // Issue rd=5, deliver 0xDEADBEEF with pipe idle.
        lu_issue_i = 1'b1; lu_issue_rd_i = 5'd5; rs1_addr_i = 5'd5;
        settle();
        chk("t2_hazard_issue_cyc", 32'(hazard_o), 32'd0);
        step();
        lu_issue_i = 1'b0;
        lu_valid_i = 1'b1; lu_waddr_i = 5'd5; lu_wdata_i = 32'hDEADBEEF;
        settle();
        chk("t2_hazard_pending", 32'(hazard_o), 32'd1);
        chk("t2_ready_accept",   32'(lu_ready_o), 32'd1);
        chk("t2_no_same_cyc_wr", 32'(regf_write_o), 32'd0);
        step();
        lu_valid_i = 1'b0;
        settle();
        chk("t2_commit_write", 32'(regf_write_o), 32'd1);
        chk("t2_commit_addr",  32'(regf_waddr_o), 32'd5);
        chk("t2_commit_data",  regf_wdata_o, 32'hDEADBEEF);
        chk("t2_ready_full",   32'(lu_ready_o), 32'd0);
        chk("t2_hazard_commit_cyc", 32'(hazard_o), 32'd1);
        step();
        settle();
        chk("t2_after_write",  32'(regf_write_o), 32'd0);
        chk("t2_after_hazard", 32'(hazard_o), 32'd0);
        chk("t2_after_ready",  32'(lu_ready_o), 32'd1);

        // Starvation: buffer holds rd=7 while pipe writes x3 back-to-back.
        lu_issue_i = 1'b1; lu_issue_rd_i = 5'd7; rs1_addr_i = 5'd7;
        step();
        lu_issue_i = 1'b0;
        lu_valid_i = 1'b1; lu_waddr_i = 5'd7; lu_wdata_i = 32'h0000_0077;
        pipe_write_i = 1'b1; pipe_waddr_i = 5'd3; pipe_wdata_i = 32'h0000_0033;
        settle();
        chk("t3_pipe_addr_accept", 32'(regf_waddr_o), 32'd3);
        chk("t3_hazard_rs1_7",     32'(hazard_o), 32'd1);
        step();
        lu_valid_i = 1'b0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            settle();
            chk($sformatf("t3_stall_low_%0d", i), 32'(pipe_stall_o), 32'd0);
            chk($sformatf("t3_pipe_wins_%0d", i), 32'(regf_waddr_o), 32'd3);
            step();
        end
        settle();
        chk("t3_stall_high", 32'(pipe_stall_o), 32'd1);
        pipe_write_i = 1'b0;
        settle();
        chk("t3_bubble_write", 32'(regf_write_o), 32'd1);
        chk("t3_bubble_addr",  32'(regf_waddr_o), 32'd7);
        chk("t3_bubble_data",  regf_wdata_o, 32'h0000_0077);
        step();
        settle();
        chk("t3_stall_cleared", 32'(pipe_stall_o), 32'd0);
        chk("t3_ready_back",    32'(lu_ready_o), 32'd1);
        chk("t3_hazard_clear",  32'(hazard_o), 32'd0);
        chk("t3_no_write",      32'(regf_write_o), 32'd0);

        // Pipe write to x0 is a free slot for the buffered rd=9.
        lu_issue_i = 1'b1; lu_issue_rd_i = 5'd9; rs1_addr_i = 5'd0;
        step();
        lu_issue_i = 1'b0;
        lu_valid_i = 1'b1; lu_waddr_i = 5'd9; lu_wdata_i = 32'h0000_0099;
        pipe_write_i = 1'b1; pipe_waddr_i = 5'd0; pipe_wdata_i = 32'hFFFF_FFFF;
        settle();
        chk("t4_x0_not_written", 32'(regf_write_o), 32'd0);
        step();
        lu_valid_i = 1'b0;
        settle();
        chk("t4_commit_write", 32'(regf_write_o), 32'd1);
        chk("t4_commit_addr",  32'(regf_waddr_o), 32'd9);
        chk("t4_commit_data",  regf_wdata_o, 32'h0000_0099);
        step();
        pipe_write_i = 1'b0; pipe_waddr_i = 5'd0;
        settle();
        chk("t4_done_ready", 32'(lu_ready_o), 32'd1);

        // Commit of rd=4 in the same cycle as a new issue to rd=4: set wins.
        lu_issue_i = 1'b1; lu_issue_rd_i = 5'd4;
        step();
        lu_issue_i = 1'b0;
        lu_valid_i = 1'b1; lu_waddr_i = 5'd4; lu_wdata_i = 32'h0000_0044;
        pipe_write_i = 1'b1; pipe_waddr_i = 5'd3; pipe_wdata_i = 32'h0000_0033;
        step();
        lu_valid_i = 1'b0;
        pipe_write_i = 1'b0;
        lu_issue_i = 1'b1; lu_issue_rd_i = 5'd4; rd_addr_i = 5'd4;
        settle();
        chk("t5_commit_addr",   32'(regf_waddr_o), 32'd4);
        chk("t5_hazard_before", 32'(hazard_o), 32'd1);
        step();
        lu_issue_i = 1'b0;
        settle();
        chk("t5_hazard_kept", 32'(hazard_o), 32'd1);
        chk("t5_buf_empty",   32'(lu_ready_o), 32'd1);
        lu_valid_i = 1'b1; lu_waddr_i = 5'd4; lu_wdata_i = 32'h0000_0444;
        step();
        lu_valid_i = 1'b0;
        settle();
        chk("t5_second_commit", regf_wdata_o, 32'h0000_0444);
        step();
        settle();
        chk("t5_hazard_final", 32'(hazard_o), 32'd0);
        rd_addr_i = 5'd0;

        // Reset while the buffer holds rd=6 and pending[6] is set.
        lu_issue_i = 1'b1; lu_issue_rd_i = 5'd6; rs1_addr_i = 5'd6;
        step();
        lu_issue_i = 1'b0;
        lu_valid_i = 1'b1; lu_waddr_i = 5'd6; lu_wdata_i = 32'h0000_0066;
        pipe_write_i = 1'b1; pipe_waddr_i = 5'd3;
        step();
        lu_valid_i = 1'b0;
        settle();
        chk("t6_full_before_rst",   32'(lu_ready_o), 32'd0);
        chk("t6_hazard_before_rst", 32'(hazard_o), 32'd1);
        pipe_write_i = 1'b0;
        #2;
        rstn_i = 1'b0;
        settle();
        chk("t6_rst_ready",  32'(lu_ready_o), 32'd1);
        chk("t6_rst_hazard", 32'(hazard_o), 32'd0);
        chk("t6_rst_write",  32'(regf_write_o), 32'd0);
        step();
        rstn_i = 1'b1;
        step();
        settle();
        chk("t6_post_write",  32'(regf_write_o), 32'd0);
        chk("t6_post_hazard", 32'(hazard_o), 32'd0);
        chk("t6_post_stall",  32'(pipe_stall_o), 32'd0);
        step();
        settle();
        chk("t6_post_write2", 32'(regf_write_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback and a long-latency unit such as the iterative mul/div.
- The pipeline writeback has fixed priority.
- Long-latency results are held in a one-entry holding buffer and drain into free write slots.
- A starvation counter forces a pipeline bubble when the buffer has waited too long.
- A per-register pending scoreboard produces the RAW/WAW hazard signal that decode uses to stall.
- Sits between the write_back stage and the register file.

Parameters:
- MAX_WAIT, 4, cycles the buffer may be denied the port before pipe_stall_o is requested (must be >= 1).
- NUM_REGS, 32, architectural registers tracked; x0 is never pending.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- pipe_write_i  in  1  WB-stage write request
- pipe_waddr_i  in  5  WB-stage destination register
- pipe_wdata_i  in  32  WB-stage write data
- lu_valid_i  in  1  long-latency result valid
- lu_ready_o  out  1  holding buffer can accept a result
- lu_waddr_i  in  5  long-latency result destination
- lu_wdata_i  in  32  long-latency result data
- lu_issue_i  in  1  long-latency op issued this cycle
- lu_issue_rd_i  in  5  destination of the issued op
- rs1_addr_i  in  5  decode source 1
- rs2_addr_i  in  5  decode source 2
- rd_addr_i  in  5  decode destination
- hazard_o  out  1  decode must stall
- pipe_stall_o  out  1  pipeline must insert a WB bubble this cycle
- regf_write_o  out  1  register-file write enable
- regf_waddr_o  out  5  register-file write address
- regf_wdata_o  out  32  register-file write data

Behaviour:
- Reset (async, rstn_i low):
  - buf_valid=0, starve_cnt=0, pending=0.
  - Outputs at reset: lu_ready_o=1, pipe_stall_o=0, hazard_o=0, regf_write_o=0.
- Pipeline slot:
  - pipe_slot = pipe_write_i && pipe_waddr_i!=0.
  - A pipe write with address 0 counts as a free slot and is never forwarded to the register file.
- Port mux (combinational, same cycle):
  - If pipe_slot: regf_* = pipe_*.
  - Else if buf_valid: regf_* = buffer contents (commit).
  - Else: regf_write_o=0.
- Holding buffer:
  - lu_ready_o = !buf_valid (registered state; no combinational path from lu_valid_i).
  - Accept on lu_valid_i && lu_ready_o; buf_valid=1 from the next cycle.
  - A result is never accepted and committed in the same cycle, so minimum result-to-regfile latency is 1 cycle.
  - On commit, buf_valid clears at the next edge.
  - lu_ready_o therefore returns high the cycle after commit, giving a throughput of 1 result per 2 cycles.
- Starvation:
  - starve_cnt increments each cycle buf_valid && pipe_slot.
  - It resets to 0 on commit or when !buf_valid.
  - pipe_stall_o = (starve_cnt == MAX_WAIT); the output is registered.
  - Core contract: pipe_write_i=0 in every cycle pipe_stall_o=1, so the buffer commits that cycle. This is checked by an assertion.
  - starve_cnt saturates at MAX_WAIT.
- Scoreboard:
  - pending[lu_issue_rd_i] is set at the edge after lu_issue_i (x0 ignored).
  - pending[buf_waddr] is cleared at the edge after a commit.
  - Set and clear of the same index in one cycle: set wins.
  - Issuing to an already-pending rd is illegal (decode stalls on hazard_o); this is asserted.
- Hazard:
  - hazard_o = pending[rs1] | pending[rs2] | pending[rd], combinational, with x0 treated as 0.
  - No forwarding: hazard clears the cycle after commit.
- Pipe write to a pending rd is illegal; this is asserted.
- Reset mid-operation discards any buffered result and all pending bits.

Decomposition:
- riscv_pkg gains wb_src_e {WB_SRC_NONE, WB_SRC_PIPE, WB_SRC_LU} for the port-mux select and debug visibility.
- One sub-module, regf_scoreboard (NUM_REGS bits, set/clear ports, three read ports).
- The top level holds the buffer, counter and mux.

Test Plan:
- Reset, then idle: regf_write_o=0, lu_ready_o=1, hazard_o=0, pipe_stall_o=0.
- Issue rd=5, result lu_waddr=5 data 0xDEADBEEF with pipe idle: commit 1 cycle after acceptance; hazard_o on rs1=5 is high from issue until the cycle after commit.
- Buffer holds rd=7 while pipe writes x3 continuously with MAX_WAIT=4: pipe_stall_o rises after 4 denied cycles; the bubble cycle writes x7; the counter then returns to 0.
- Pipe write to x0 while the buffer holds rd=9: x9 commits that cycle and x0 is not written.
- Same cycle: commit of rd=4 and issue to rd=4: pending[4] stays 1 and hazard_o on rd=4 stays high.
- Assert rstn_i low while buf_valid=1 and pending[6]=1: buffer and scoreboard clear immediately; no write after release.
